// File: rtl/change_dispenser.sv
// Change payout engine: latches a refund amount and issues 10/5/1 dollar coins
// largest-first over a valid/ready handshake, tracking hopper inventory.
//
// state | meaning
// IDLE  | waiting for start; refill reloads inventory
// SEL   | choose the largest affordable, stocked denomination
// ISSUE | present coin, wait for coin_ready
// DONE  | one-cycle done pulse, report short/residual
module change_dispenser #(
    parameter int CNT_W    = 8,
    parameter int INIT_N10 = 20,
    parameter int INIT_N5  = 20,
    parameter int INIT_N1  = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       amount,
    input  logic             refill,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [7:0]       residual,
    output logic [CNT_W-1:0] inv10,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv1
);

    typedef enum logic [1:0] {IDLE, SEL, ISSUE, DONE} state_t;

    localparam logic [1:0] SEL_10 = 2'd1;
    localparam logic [1:0] SEL_5  = 2'd2;
    localparam logic [1:0] SEL_1  = 2'd3;

    state_t     state;
    logic [7:0] remain;
    logic [7:0] coin_val;
    logic [7:0] remain_next;

    always_comb begin
        coin_val = 8'd0;
        case (coin_sel)
            SEL_10:  coin_val = 8'd10;
            SEL_5:   coin_val = 8'd5;
            SEL_1:   coin_val = 8'd1;
            default: coin_val = 8'd0;
        endcase
    end

    // coin_sel is only ever picked with coin_val <= remain, so no underflow
    assign remain_next = remain - coin_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            remain     <= 8'd0;
            coin_valid <= 1'b0;
            coin_sel   <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            residual   <= 8'd0;
            inv10      <= CNT_W'(INIT_N10);
            inv5       <= CNT_W'(INIT_N5);
            inv1       <= CNT_W'(INIT_N1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remain   <= amount;
                        short    <= 1'b0;
                        residual <= 8'd0;
                        busy     <= 1'b1;
                        if (amount == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEL;
                        end
                    end else if (refill) begin
                        inv10 <= CNT_W'(INIT_N10);
                        inv5  <= CNT_W'(INIT_N5);
                        inv1  <= CNT_W'(INIT_N1);
                    end
                end
                SEL: begin
                    if (remain >= 8'd10 && inv10 != '0) begin
                        coin_sel   <= SEL_10;
                        coin_valid <= 1'b1;
                        state      <= ISSUE;
                    end else if (remain >= 8'd5 && inv5 != '0) begin
                        coin_sel   <= SEL_5;
                        coin_valid <= 1'b1;
                        state      <= ISSUE;
                    end else if (remain >= 8'd1 && inv1 != '0) begin
                        coin_sel   <= SEL_1;
                        coin_valid <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        short    <= (remain != 8'd0);
                        residual <= remain;
                    end
                end
                ISSUE: begin
                    if (coin_ready) begin
                        remain     <= remain_next;
                        coin_valid <= 1'b0;
                        coin_sel   <= 2'd0;
                        case (coin_sel)
                            SEL_10: if (inv10 != '0) inv10 <= inv10 - CNT_W'(1);
                            SEL_5:  if (inv5 != '0)  inv5  <= inv5 - CNT_W'(1);
                            SEL_1:  if (inv1 != '0)  inv1  <= inv1 - CNT_W'(1);
                            default: ;
                        endcase
                        if (remain_next == 8'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            short    <= 1'b0;
                            residual <= 8'd0;
                        end else begin
                            state <= SEL;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout sequences, latency, inventory,
// stall, shortage, reset-mid-payout and ignored inputs while busy.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] amount;
    logic       refill;
    logic       coin_ready;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       short;
    logic [7:0] residual;
    logic [7:0] inv10, inv5, inv1;

    int checks = 0;
    int passes = 0;
    logic [1:0] seq [0:63];
    int nseq;

    change_dispenser #(.CNT_W(8), .INIT_N10(20), .INIT_N5(20), .INIT_N1(50)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
        .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .busy(busy), .done(done), .short(short), .residual(residual),
        .inv10(inv10), .inv5(inv5), .inv1(inv1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a payout and records handshaken coins; cyc = cycles from start to done, -1 on timeout.
    task automatic do_payout(input logic [7:0] amt, input bit noise, output int cyc);
        nseq = 0;
        cyc  = -1;
        start  = 1'b1;
        amount = amt;
        tick();
        if (noise) begin
            amount = 8'd99;
            refill = 1'b1;
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c < 200; c++) begin
            if (coin_valid && coin_ready && nseq < 64) begin
                seq[nseq] = coin_sel;
                nseq++;
            end
            if (done) begin
                cyc = c;
                start  = 1'b0;
                refill = 1'b0;
                break;
            end
            tick();
        end
        start  = 1'b0;
        refill = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; amount = 8'd0; refill = 1'b0; coin_ready = 1'b1;
        tick(); tick();
        checks++; if ({coin_valid, coin_sel, busy, done, short, residual} !== 14'd0)
            $display("FAIL reset_outputs got %h expected 0", {coin_valid, coin_sel, busy, done, short, residual});
        else passes++;
        checks++; if ({inv10, inv5, inv1} !== {8'd20, 8'd20, 8'd50})
            $display("FAIL reset_inventory got %0d/%0d/%0d expected 20/20/50", inv10, inv5, inv1);
        else passes++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_payout_37();
        int cyc;
        logic [1:0] exp_seq [0:5];
        exp_seq = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        do_payout(8'd37, 1'b0, cyc);
        checks++; if (nseq !== 6) $display("FAIL p37_coin_count got %0d expected 6", nseq); else passes++;
        for (int i = 0; i < 6; i++) begin
            checks++; if (seq[i] !== exp_seq[i])
                $display("FAIL p37_coin_sel[%0d] got %0d expected %0d", i, seq[i], exp_seq[i]);
            else passes++;
        end
        checks++; if (cyc !== 13) $display("FAIL p37_latency got %0d expected 13", cyc); else passes++;
        checks++; if ({short, residual} !== 9'd0)
            $display("FAIL p37_short_residual got %0d/%0d expected 0/0", short, residual);
        else passes++;
        checks++; if ({inv10, inv5, inv1} !== {8'd17, 8'd19, 8'd48})
            $display("FAIL p37_inventory got %0d/%0d/%0d expected 17/19/48", inv10, inv5, inv1);
        else passes++;
        tick();
    endtask

    task automatic test_zero_with_refill();
        start = 1'b1; amount = 8'd0; refill = 1'b1;
        tick();
        start = 1'b0; refill = 1'b0;
        checks++; if ({done, busy, coin_valid, short, residual} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL zero_done got done=%0d busy=%0d valid=%0d short=%0d res=%0d expected 1 1 0 0 0",
                     done, busy, coin_valid, short, residual);
        else passes++;
        tick();
        checks++; if ({done, busy} !== 2'b00)
            $display("FAIL zero_after got done=%0d busy=%0d expected 0 0", done, busy);
        else passes++;
        checks++; if ({inv10, inv5, inv1} !== {8'd17, 8'd19, 8'd48})
            $display("FAIL start_beats_refill got %0d/%0d/%0d expected 17/19/48", inv10, inv5, inv1);
        else passes++;
    endtask

    task automatic test_refill();
        refill = 1'b1;
        tick();
        refill = 1'b0;
        checks++; if ({inv10, inv5, inv1} !== {8'd20, 8'd20, 8'd50})
            $display("FAIL refill got %0d/%0d/%0d expected 20/20/50", inv10, inv5, inv1);
        else passes++;
    endtask

    task automatic test_busy_ignore();
        int cyc;
        do_payout(8'd15, 1'b1, cyc);
        checks++; if (cyc !== 5) $display("FAIL busy_latency got %0d expected 5", cyc); else passes++;
        checks++; if (nseq !== 2 || seq[0] !== 2'd1 || seq[1] !== 2'd2)
            $display("FAIL busy_coins got n=%0d first=%0d second=%0d expected 2 1 2", nseq, seq[0], seq[1]);
        else passes++;
        checks++; if ({inv10, inv5, inv1} !== {8'd19, 8'd19, 8'd50})
            $display("FAIL busy_refill_ignored got %0d/%0d/%0d expected 19/19/50", inv10, inv5, inv1);
        else passes++;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0)
            $display("FAIL busy_start_not_queued got busy=%0d expected 0", busy);
        else passes++;
    endtask

    task automatic test_ready_stall();
        test_refill();
        coin_ready = 1'b0;
        start = 1'b1; amount = 8'd7;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({coin_valid, coin_sel, inv5} !== {1'b1, 2'd2, 8'd20})
                $display("FAIL stall_hold[%0d] got valid=%0d sel=%0d inv5=%0d expected 1 2 20",
                         i, coin_valid, coin_sel, inv5);
            else passes++;
            if (i < 4) tick();
        end
        coin_ready = 1'b1;
        tick();
        checks++; if ({coin_valid, inv5} !== {1'b0, 8'd19})
            $display("FAIL stall_release got valid=%0d inv5=%0d expected 0 19", coin_valid, inv5);
        else passes++;
        for (int i = 0; i < 20 && !done; i++) tick();
        checks++; if ({done, short, inv1} !== {1'b1, 1'b0, 8'd48})
            $display("FAIL stall_finish got done=%0d short=%0d inv1=%0d expected 1 0 48", done, short, inv1);
        else passes++;
        tick();
    endtask

    task automatic test_skip();
        int cyc;
        test_refill();
        do_payout(8'd200, 1'b0, cyc);
        checks++; if (cyc !== 41 || inv10 !== 8'd0 || short !== 1'b0)
            $display("FAIL drain10 got cyc=%0d inv10=%0d short=%0d expected 41 0 0", cyc, inv10, short);
        else passes++;
        tick();
        do_payout(8'd20, 1'b0, cyc);
        checks++; if (nseq !== 4) $display("FAIL skip_count got %0d expected 4", nseq); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq[i] !== 2'd2) $display("FAIL skip_sel[%0d] got %0d expected 2", i, seq[i]);
            else passes++;
        end
        checks++; if ({inv5, short, residual} !== {8'd16, 1'b0, 8'd0})
            $display("FAIL skip_result got inv5=%0d short=%0d res=%0d expected 16 0 0", inv5, short, residual);
        else passes++;
        tick();
    endtask

    task automatic test_short();
        int cyc;
        do_payout(8'd80, 1'b0, cyc);
        tick();
        do_payout(8'd49, 1'b0, cyc);
        tick();
        checks++; if ({inv10, inv5, inv1} !== {8'd0, 8'd0, 8'd1})
            $display("FAIL short_setup got %0d/%0d/%0d expected 0/0/1", inv10, inv5, inv1);
        else passes++;
        do_payout(8'd3, 1'b0, cyc);
        checks++; if (nseq !== 1 || seq[0] !== 2'd3 || cyc !== 4)
            $display("FAIL short_coins got n=%0d sel=%0d cyc=%0d expected 1 3 4", nseq, seq[0], cyc);
        else passes++;
        checks++; if ({short, residual, inv1} !== {1'b1, 8'd2, 8'd0})
            $display("FAIL short_flag got short=%0d res=%0d inv1=%0d expected 1 2 0", short, residual, inv1);
        else passes++;
        tick(); tick(); tick();
        checks++; if ({done, short, residual} !== {1'b0, 1'b1, 8'd2})
            $display("FAIL short_hold got done=%0d short=%0d res=%0d expected 0 1 2", done, short, residual);
        else passes++;
    endtask

    task automatic test_reset_mid();
        test_refill();
        start = 1'b1; amount = 8'd37;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if ({coin_valid, coin_sel, inv10} !== {1'b1, 2'd1, 8'd19})
            $display("FAIL mid_pre got valid=%0d sel=%0d inv10=%0d expected 1 1 19", coin_valid, coin_sel, inv10);
        else passes++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if ({coin_valid, coin_sel, busy, done, short, residual} !== 14'd0)
            $display("FAIL mid_reset_outputs got %h expected 0", {coin_valid, coin_sel, busy, done, short, residual});
        else passes++;
        checks++; if ({inv10, inv5, inv1} !== {8'd20, 8'd20, 8'd50})
            $display("FAIL mid_reset_inventory got %0d/%0d/%0d expected 20/20/50", inv10, inv5, inv1);
        else passes++;
        tick(); tick();
        checks++; if ({busy, coin_valid} !== 2'b00)
            $display("FAIL mid_reset_idle got busy=%0d valid=%0d expected 0 0", busy, coin_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_payout_37();
        test_zero_with_refill();
        test_refill();
        test_busy_ignore();
        test_ready_stall();
        test_skip();
        test_short();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of the vending machine controller, this block pays out change.
- On the controller's exchange event it latches the refund amount.
- It pays the amount out as physical coins (10, 5, 1 dollars) through a valid/ready handshake to the coin hopper, using a greedy largest-coin-first policy.
- It tracks per-denomination hopper inventory.
- It reports any amount it could not pay.

Parameters:
- CNT_W, 8, width of each inventory counter.
- INIT_N10, 20, 10-dollar coins loaded at reset/refill.
- INIT_N5, 20, 5-dollar coins loaded at reset/refill.
- INIT_N1, 50, 1-dollar coins loaded at reset/refill.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- start  in  1  one-cycle request to pay out amount.
- amount  in  8  refund value in dollars, sampled when start accepted.
- refill  in  1  reload inventory counters to INIT_* values.
- coin_ready  in  1  hopper accepts the presented coin.
- coin_valid  out  1  a coin is being presented.
- coin_sel  out  2  presented denomination: 1=10, 2=5, 3=1, 0=none.
- busy  out  1  payout in progress (state != IDLE).
- done  out  1  one-cycle pulse at payout end.
- short  out  1  valid with done: change could not be fully paid.
- residual  out  8  unpaid dollars, valid with done; 0 when short=0.
- inv10, inv5, inv1  out  CNT_W  current coin inventory.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE.
  - coin_valid, coin_sel, busy, done, short and residual are all 0.
  - inv10/inv5/inv1 = INIT_N10/INIT_N5/INIT_N1.
  - remain register = 0.
  - Reset overrides everything, including a payout in progress. A coin mid-handshake is dropped and inventory is not decremented for it.
- States: IDLE, SEL, ISSUE, DONE.
- IDLE:
  - start=1 latches remain=amount.
  - If amount==0, next state is DONE; otherwise next state is SEL.
  - refill=1 with start=0 reloads inventory. If refill and start are both 1, start wins and refill is ignored.
- SEL (one cycle, coin_valid=0):
  - Pick the largest d in {10,5,1} with d<=remain and inv_d>0.
  - If one is found, register coin_sel and go to ISSUE.
  - If none is found, go to DONE with short=1.
- ISSUE:
  - coin_valid=1; coin_sel is held stable until the handshake.
  - On a rising edge with coin_ready=1: remain-=d and inv_d-=1.
  - Then go to DONE if the new remain==0, else go to SEL.
  - coin_ready=0 holds the block in ISSUE indefinitely with no timeout.
- DONE (one cycle):
  - done=1; residual=remain; short=(remain!=0).
  - Next state is IDLE.
  - short and residual hold their values until the next start is accepted; done is one cycle only.
- busy=1 in SEL, ISSUE and DONE.
- start and refill outside IDLE are ignored, not queued.
- Arithmetic:
  - remain is 8-bit unsigned and never underflows, because d<=remain is checked in SEL.
  - Inventory counters never go below 0 and saturate (no wrap).
  - refill loads the counters, it does not add to them.
- Latency with coin_ready tied high:
  - Each coin costs 2 cycles (SEL + ISSUE).
  - done asserts 2*N+1 cycles after the start edge for N coins.
  - amount==0 gives done 1 cycle after start.
- Denomination skip: an exhausted larger denomination falls through to smaller ones. With inv10=0, 20 pays as four 5s.

Test Plan:
- Full inventory, coin_ready=1, start with amount=37 → coin_sel sequence 1,1,1,2,3,3. done 13 cycles after start, short=0, residual=0, inv10=17, inv5=19, inv1=48.
- amount=0 → no coin_valid; done next cycle with short=0, residual=0.
- inv10=0 (drain first), amount=20 → four coins with coin_sel=2, inv5 decreases by 4, short=0.
- inv1=1, inv5=0, inv10=0, amount=3 → one 1-dollar coin, then done with short=1, residual=2.
- coin_ready held low 5 cycles in ISSUE → coin_valid and coin_sel stable, inventory unchanged; the transfer completes on the first coin_ready=1 edge.
- rst=0 during ISSUE of a 37 payout:
  - Next cycle: IDLE, all outputs 0, inventory back to INIT values.
  - start during busy, and refill during busy, are verified ignored.
